// File: rtl/aes_blk_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// aes_blk_scheduler_pkg
// Shared definitions for the AES block scheduler: FSM state encoding and the
// bit positions of the command word fields.
// -----------------------------------------------------------------------------
package aes_blk_scheduler_pkg;

  localparam int CMD_WIDTH       = 32;
  localparam int CMD_DECRYPT_BIT = 0;  // 1 = run the core in decrypt mode
  localparam int CMD_KEY_BIT     = 1;  // 1 = block 0 of the input RAM is the key

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    READ      = 3'd1,
    LATCH     = 3'd2,
    ISSUE     = 3'd3,
    WAIT_CORE = 3'd4,
    WRITE     = 3'd5,
    FINISH    = 3'd6
  } state_t;

endpackage

// File: rtl/aes_blk_scheduler_if.sv
// -----------------------------------------------------------------------------
// aes_blk_scheduler_if
// Groups the three buses the scheduler talks to:
//   input RAM read port  : in_r_e, in_addr -> RAM ; in_data <- RAM (1-cycle latency)
//   AES core             : core_start, core_decrypt, core_key_load, core_data_o -> core
//                          core_done, core_data_i <- core
//   output RAM write port: out_w_e, out_addr, out_data -> RAM
// master = scheduler side, slave = RAM/core side.
// -----------------------------------------------------------------------------
interface aes_blk_scheduler_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 128
) ();

  logic                  in_r_e;
  logic [ADDR_WIDTH-1:0] in_addr;
  logic [DATA_WIDTH-1:0] in_data;

  logic                  core_start;
  logic                  core_decrypt;
  logic                  core_key_load;
  logic [DATA_WIDTH-1:0] core_data_o;
  logic                  core_done;
  logic [DATA_WIDTH-1:0] core_data_i;

  logic                  out_w_e;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic [DATA_WIDTH-1:0] out_data;

  modport master (
    output in_r_e, in_addr,
    input  in_data,
    output core_start, core_decrypt, core_key_load, core_data_o,
    input  core_done, core_data_i,
    output out_w_e, out_addr, out_data
  );

  modport slave (
    input  in_r_e, in_addr,
    output in_data,
    input  core_start, core_decrypt, core_key_load, core_data_o,
    output core_done, core_data_i,
    input  out_w_e, out_addr, out_data
  );

endinterface

// File: rtl/aes_blk_scheduler.sv
// -----------------------------------------------------------------------------
// aes_blk_scheduler
// Streams blk_cnt 128-bit blocks from an input RAM through an AES core and
// writes the results to an output RAM. When cmd[CMD_KEY_BIT] is set, block 0
// is handed to the core as a key load and produces no output write, so data
// results land at out_addr = idx - 1.
//
// Ports:
//   clk      : rising-edge clock
//   aresetn  : asynchronous active-low reset
//   en       : one-cycle start strobe, honoured only in IDLE
//   cmd      : command word (bit0 decrypt, bit1 first block is key)
//   blk_cnt  : number of blocks in the input RAM, key block included
//   busy     : high from the cycle after an accepted en until done
//   done     : one-cycle completion strobe
//   bus      : RAM read port, AES core and RAM write port (master side)
//
// Timing: every bus output is registered on entry to the state that owns it,
// so in_r_e is visible during READ, core_start during ISSUE and out_w_e during
// WRITE. done/busy are updated by the FINISH state itself, which makes an
// empty job produce done two cycles after en.
// -----------------------------------------------------------------------------
module aes_blk_scheduler
  import aes_blk_scheduler_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic                  en,
  input  logic [CMD_WIDTH-1:0]  cmd,
  input  logic [ADDR_WIDTH-1:0] blk_cnt,
  output logic                  busy,
  output logic                  done,
  aes_blk_scheduler_if.master   bus
);

  state_t                state;
  logic                  rst_seen;     // one clean edge seen since reset release
  logic                  cmd_decrypt_r;
  logic                  cmd_key_r;
  logic [ADDR_WIDTH-1:0] blk_cnt_r;
  logic [ADDR_WIDTH-1:0] idx;
  logic [DATA_WIDTH-1:0] blk_reg;
  logic [DATA_WIDTH-1:0] res_reg;

  logic key_blk;
  logic last_blk;
  logic advance;
  logic unused_cmd_bits;

  assign key_blk  = cmd_key_r && (idx == '0);
  // blk_cnt_r is never 0 outside IDLE/FINISH, so the subtraction cannot wrap
  // in any state where last_blk is used.
  assign last_blk = (idx == blk_cnt_r - ADDR_WIDTH'(1));
  // Move to the next block after a write, or straight after a key load.
  assign advance  = (state == WRITE) ||
                    ((state == WAIT_CORE) && bus.core_done && key_blk);

  assign unused_cmd_bits = ^cmd[CMD_WIDTH-1:2];

  assign bus.core_data_o = blk_reg;
  assign bus.out_data    = res_reg;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order; the
  // later 'advance' assignments deliberately override the case body.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state             <= IDLE;
      rst_seen          <= 1'b0;
      cmd_decrypt_r     <= 1'b0;
      cmd_key_r         <= 1'b0;
      blk_cnt_r         <= '0;
      idx               <= '0;
      blk_reg           <= '0;
      res_reg           <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      bus.in_r_e        <= 1'b0;
      bus.in_addr       <= '0;
      bus.core_start    <= 1'b0;
      bus.core_decrypt  <= 1'b0;
      bus.core_key_load <= 1'b0;
      bus.out_w_e       <= 1'b0;
      bus.out_addr      <= '0;
    end else begin
      rst_seen <= 1'b1;

      // Strobes default low and are raised only for their single cycle.
      bus.in_r_e        <= 1'b0;
      bus.core_start    <= 1'b0;
      bus.core_decrypt  <= 1'b0;
      bus.core_key_load <= 1'b0;
      bus.out_w_e       <= 1'b0;
      done              <= 1'b0;

      case (state)
        IDLE: begin
          if (en && rst_seen) begin
            cmd_decrypt_r <= cmd[CMD_DECRYPT_BIT];
            cmd_key_r     <= cmd[CMD_KEY_BIT];
            blk_cnt_r     <= blk_cnt;
            idx           <= '0;
            busy          <= 1'b1;
            if (blk_cnt == '0) begin
              state <= FINISH;
            end else begin
              state       <= READ;
              bus.in_r_e  <= 1'b1;
              bus.in_addr <= '0;
            end
          end
        end

        READ: state <= LATCH;

        LATCH: begin
          blk_reg           <= bus.in_data;
          state             <= ISSUE;
          bus.core_start    <= 1'b1;
          bus.core_decrypt  <= cmd_decrypt_r;
          bus.core_key_load <= key_blk;
        end

        ISSUE: state <= WAIT_CORE;

        WAIT_CORE: begin
          if (bus.core_done) begin
            res_reg <= bus.core_data_i;
            if (!key_blk) begin
              state        <= WRITE;
              bus.out_w_e  <= 1'b1;
              bus.out_addr <= idx - ADDR_WIDTH'(cmd_key_r);
            end
          end
        end

        WRITE: state <= WRITE;  // replaced by the advance step below

        FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase

      if (advance) begin
        if (last_blk) begin
          state <= FINISH;
        end else begin
          idx         <= idx + ADDR_WIDTH'(1);
          state       <= READ;
          bus.in_r_e  <= 1'b1;
          bus.in_addr <= idx + ADDR_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_aes_blk_scheduler.sv
// -----------------------------------------------------------------------------
// tb_aes_blk_scheduler
// Self-checking bench: a behavioural input RAM (1-cycle read latency) and an
// AES core stand-in with programmable latency surround the scheduler. Each job
// pushes the expected core issues and output writes onto scoreboard queues;
// monitors pop and compare them as the DUT produces them.
// -----------------------------------------------------------------------------
module tb_aes_blk_scheduler;

  localparam int AW = 9;
  localparam int DW = 128;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          dec;
    logic          key;
  } issue_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          clk;
  logic          aresetn;
  logic          en;
  logic [31:0]   cmd;
  logic [AW-1:0] blk_cnt;
  logic          busy;
  logic          done;

  aes_blk_scheduler_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  aes_blk_scheduler #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk     (clk),
    .aresetn (aresetn),
    .en      (en),
    .cmd     (cmd),
    .blk_cnt (blk_cnt),
    .busy    (busy),
    .done    (done),
    .bus     (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- counters
  int n_vec = 0;
  int n_err = 0;
  int n_rd = 0, n_start = 0, n_wr = 0, n_done = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference core transform: any fixed bijection distinct per mode will do.
  function automatic logic [DW-1:0] core_fn(input logic [DW-1:0] d, input logic dec);
    return {d[63:0], d[127:64]} ^ (dec ? 128'h0F0F_1234_5678_9ABC_DEF0_1357_9BDF_2468
                                       : 128'hA5A5_5A5A_C3C3_3C3C_FFFF_0000_1111_EEEE);
  endfunction

  // ---------------------------------------------------------------- input RAM
  logic [DW-1:0] in_mem [0:(1<<AW)-1];
  logic [DW-1:0] ram_q;
  always @(posedge clk) if (bus.in_r_e) ram_q <= in_mem[bus.in_addr];
  assign bus.in_data = ram_q;

  // ---------------------------------------------------------------- AES core
  int            lat = 1;
  int            core_cnt = 0;
  logic          core_done_m = 1'b0;
  logic          spur = 1'b0;
  logic [DW-1:0] core_res = '0;
  logic [DW-1:0] held_data = '0;
  logic          held_dec = 1'b0;

  assign bus.core_done   = core_done_m | spur;
  assign bus.core_data_i = core_res;

  // core_done rises 'lat' cycles after the cycle in which core_start is seen.
  always @(negedge clk) begin
    if (!aresetn) begin
      core_cnt    = 0;
      core_done_m = 1'b0;
    end else begin
      core_done_m = 1'b0;
      if (core_cnt > 0) begin
        core_cnt--;
        if (core_cnt == 0) begin
          core_done_m = 1'b1;
          core_res    = core_fn(held_data, held_dec);
        end
      end
      if (bus.core_start) begin
        held_data = bus.core_data_o;
        held_dec  = bus.core_decrypt;
        core_cnt  = lat;
      end
    end
  end

  // ---------------------------------------------------------------- scoreboard
  issue_t issue_q[$];
  wr_t    wr_q[$];
  issue_t exp_is;
  wr_t    exp_wr;

  always @(negedge clk) begin
    if (bus.in_r_e) n_rd++;
    if (done)       n_done++;
    if (bus.core_start) begin
      n_start++;
      if (issue_q.size() == 0) begin
        check("issue_unexpected", 1, 0);
      end else begin
        exp_is = issue_q.pop_front();
        check("issue_data", bus.core_data_o, exp_is.data);
        check("issue_dec",  bus.core_decrypt, exp_is.dec);
        check("issue_key",  bus.core_key_load, exp_is.key);
      end
    end
    if (bus.out_w_e) begin
      n_wr++;
      if (wr_q.size() == 0) begin
        check("wr_unexpected", 1, 0);
      end else begin
        exp_wr = wr_q.pop_front();
        check("wr_addr", bus.out_addr, exp_wr.addr);
        check("wr_data", bus.out_data, exp_wr.data);
      end
    end
  end

  // ---------------------------------------------------------------- job runner
  // disturb: spurious core_done in IDLE and READ, plus en re-asserted while busy.
  task automatic run_job(input string tag, input logic [31:0] c, input int cnt,
                         input int l, input bit disturb);
    int edges, exp_edges, k, d0, w0, r0, s0;
    bit seen;
    logic [AW-1:0] a;
    lat = l;
    k   = (c[1] && cnt > 0) ? 1 : 0;
    for (int i = 0; i < cnt; i++) begin
      in_mem[i] = {$urandom, $urandom, $urandom, $urandom};
      issue_q.push_back('{data: in_mem[i], dec: c[0], key: (c[1] && i == 0)});
      if (!(c[1] && i == 0)) begin
        a = AW'(i) - AW'(c[1]);
        wr_q.push_back('{addr: a, data: core_fn(in_mem[i], c[0])});
      end
    end
    // Edges counted from the en drive: one accept edge, the block cycles
    // (4+lat each, one fewer for the key block), then the FINISH edge.
    exp_edges = cnt * (4 + l) - k + 2;
    d0 = n_done; w0 = n_wr; r0 = n_rd; s0 = n_start;

    if (disturb) begin
      spur = 1'b1;
      @(negedge clk);
      spur = 1'b0;
    end

    en = 1'b1; cmd = c; blk_cnt = AW'(cnt);
    edges = 0; seen = 1'b0;
    while (!seen && edges < exp_edges + 40) begin
      @(negedge clk);
      edges++;
      if (edges == 1) begin
        en = 1'b0;
        check({tag, "_busy"}, busy, 1'b1);
        if (disturb) spur = 1'b1;
      end
      if (disturb && edges == 2) spur = 1'b0;
      if (disturb && edges == 5) begin en = 1'b1; cmd = 32'h3; blk_cnt = 7; end
      if (disturb && edges == 6) en = 1'b0;
      if (done) seen = 1'b1;
    end
    check({tag, "_done_lat"}, edges, exp_edges);
    check({tag, "_busy_off"}, busy, 1'b0);
    repeat (3) @(negedge clk);
    check({tag, "_done_cnt"}, n_done - d0, 1);
    check({tag, "_wr_cnt"},   n_wr - w0, cnt - k);
    check({tag, "_rd_cnt"},   n_rd - r0, cnt);
    check({tag, "_st_cnt"},   n_start - s0, cnt);
    check({tag, "_q_empty"},  issue_q.size() + wr_q.size(), 0);
  endtask

  // ---------------------------------------------------------------- sequence
  int d0;

  initial begin
    aresetn = 1'b0; en = 1'b0; cmd = '0; blk_cnt = '0;
    repeat (3) @(negedge clk);
    check("rst_ctrl", {busy, done, bus.in_r_e, bus.core_start, bus.core_decrypt,
                       bus.core_key_load, bus.out_w_e}, 7'd0);
    check("rst_in_addr",  bus.in_addr, 0);
    check("rst_out_addr", bus.out_addr, 0);
    check("rst_core_data", bus.core_data_o, 0);

    // en held across reset release must be ignored on the first clean edge.
    aresetn = 1'b1; en = 1'b1; cmd = '0; blk_cnt = 1;
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check("en_at_release", busy, 1'b0);
    check("en_at_release_rd", n_rd, 0);

    run_job("key3",    32'h2, 3, 10, 1'b0);
    run_job("dec2",    32'h1, 2, 5,  1'b0);
    run_job("zero",    32'h0, 0, 3,  1'b0);
    run_job("keyonly", 32'h2, 1, 2,  1'b0);
    run_job("disturb", 32'h0, 2, 3,  1'b1);

    // Reset dropped while the core is busy.
    lat = 10;
    in_mem[0] = {$urandom, $urandom, $urandom, $urandom};
    issue_q.push_back('{data: in_mem[0], dec: 1'b0, key: 1'b0});
    en = 1'b1; cmd = '0; blk_cnt = 1;
    for (int e = 1; e <= 6; e++) begin
      @(negedge clk);
      if (e == 1) en = 1'b0;
    end
    check("pre_rst_busy", busy, 1'b1);
    d0 = n_done;
    aresetn = 1'b0;
    #1;
    check("midrst_ctrl", {busy, done, bus.in_r_e, bus.core_start, bus.core_decrypt,
                          bus.core_key_load, bus.out_w_e, bus.in_addr, bus.out_addr}, 0);
    check("midrst_core_data", bus.core_data_o, 0);
    check("midrst_out_data",  bus.out_data, 0);
    repeat (2) @(negedge clk);
    issue_q.delete();
    wr_q.delete();
    aresetn = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_no_done", n_done - d0, 0);
    run_job("restart", 32'h0, 1, 4, 1'b0);

    run_job("full", 32'h0, 511, 1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
